// File: rtl/filt_seq_ctrl_if.sv
// Host-side command/response channels of the filter sequencer.
interface filt_seq_ctrl_if #(
    parameter int unsigned DW = 8
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_op;

    // Host side
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_op
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_op
    );
endinterface

// File: rtl/filt_seq_ctrl.sv
// Command sequencer for the min/max/average filter core: runs the core warm-up,
// then steps the core once per host command and returns the captured output.
module filt_seq_ctrl #(
    parameter int unsigned    DW    = 8,
    parameter logic [DW-1:0]  SEED  = '0,
    parameter int unsigned    CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    filt_seq_ctrl_if.slave   bus,
    output logic             core_step,
    output logic             core_restart,
    output logic             core_average,
    output logic             core_enable,
    output logic [DW-1:0]    core_data_in,
    input  logic [DW-1:0]    core_data_out,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [2:0] {StWarm0, StWarm1, StIdle, StExec, StCapt, StResp} state_e;

    localparam logic [1:0] OpSample  = 2'b00;
    localparam logic [1:0] OpAverage = 2'b01;
    localparam logic [1:0] OpRestart = 2'b10;

    state_e           state_q, state_d;
    // WARM0 is entered from reset with all outputs low; this marks that its
    // core step has been issued so the following edge moves on to WARM1.
    logic             warm0_seen_q, warm0_seen_d;
    logic [1:0]       op_q, op_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_op_q, rsp_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;
    logic             restart_q, restart_d;
    logic             average_q, average_d;
    logic             enable_q, enable_d;
    logic [DW-1:0]    din_q, din_d;

    // Next state, command/response latches, counter, and outputs decoded from next state
    always_comb begin
        state_d      = state_q;
        warm0_seen_d = 1'b1;
        op_d         = op_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_op_d     = rsp_op_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StWarm0: state_d = warm0_seen_q ? StWarm1 : StWarm0;
            StWarm1: state_d = StIdle;
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    data_d  = bus.cmd_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                // SAMPLE and AVERAGE are the enabled opcodes (op[1] == 0)
                if (!op_q[1] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                state_d = StCapt;
            end
            StCapt: begin
                rsp_data_d = core_data_out;
                rsp_op_d   = op_q;
                state_d    = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StWarm0;
        endcase

        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        busy_d      = (state_d != StIdle);
        step_d      = (state_d == StWarm0) || (state_d == StWarm1) || (state_d == StExec);
        enable_d    = (state_d == StExec) && ((op_d == OpSample) || (op_d == OpAverage));
        average_d   = (state_d == StExec) && (op_d == OpAverage);
        restart_d   = (state_d == StExec) && (op_d == OpRestart);
        if (state_d == StExec) begin
            din_d = data_d;
        end else if (state_d == StWarm1) begin
            din_d = SEED;
        end else begin
            din_d = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StWarm0;
            warm0_seen_q <= 1'b0;
            op_q         <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_op_q     <= '0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
            step_q       <= 1'b0;
            restart_q    <= 1'b0;
            average_q    <= 1'b0;
            enable_q     <= 1'b0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            warm0_seen_q <= warm0_seen_d;
            op_q         <= op_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            rsp_op_q     <= rsp_op_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            restart_q    <= restart_d;
            average_q    <= average_d;
            enable_q     <= enable_d;
            din_q        <= din_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_op    = rsp_op_q;
    assign core_step     = step_q;
    assign core_restart  = restart_q;
    assign core_average  = average_q;
    assign core_enable   = enable_q;
    assign core_data_in  = din_q;
    assign busy          = busy_q;
    assign sample_count  = cnt_q;

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Directed bench for filt_seq_ctrl: warm-up, per-opcode controls, response
// backpressure, reset during a response and counter saturation (CNT_W=2 copy).
module tb_filt_seq_ctrl;

    localparam logic [7:0] Seed = 8'h5A;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  core_out;
    logic [7:0]  stub_next;
    logic        jitter;

    logic        step1, rst1, avg1, en1;
    logic [7:0]  din1;
    logic [15:0] cnt1;
    logic        busy1;
    logic        step2, rst2, avg2, en2;
    logic [7:0]  din2;
    logic [1:0]  cnt2;
    logic        busy2;

    int n_checks = 0;
    int n_pass   = 0;

    filt_seq_ctrl_if #(.DW(8)) bus1 ();
    filt_seq_ctrl_if #(.DW(8)) bus2 ();

    // The saturation copy sees exactly the same host traffic
    assign bus2.cmd_valid = bus1.cmd_valid;
    assign bus2.cmd_op    = bus1.cmd_op;
    assign bus2.cmd_data  = bus1.cmd_data;
    assign bus2.rsp_ready = bus1.rsp_ready;

    filt_seq_ctrl #(.DW(8), .SEED(Seed), .CNT_W(16)) u_dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .bus           (bus1),
        .core_step     (step1),
        .core_restart  (rst1),
        .core_average  (avg1),
        .core_enable   (en1),
        .core_data_in  (din1),
        .core_data_out (core_out),
        .busy          (busy1),
        .sample_count  (cnt1)
    );

    filt_seq_ctrl #(.DW(8), .SEED(Seed), .CNT_W(2)) u_dut_sat (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .bus           (bus2),
        .core_step     (step2),
        .core_restart  (rst2),
        .core_average  (avg2),
        .core_enable   (en2),
        .core_data_in  (din2),
        .core_data_out (core_out),
        .busy          (busy2),
        .sample_count  (cnt2)
    );

    always #5 CLOCK = ~CLOCK;

    // Core stub: output register updates on step edges; optional drift otherwise
    always @(posedge CLOCK) begin
        if (step1) begin
            core_out <= stub_next;
        end else if (jitter) begin
            core_out <= core_out + 8'h11;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge where RESET is released; returns at the IDLE negedge
    task automatic warm_checks();
        RESET = 1'b0;
        @(negedge CLOCK);
        check_eq("warm0_step", step1, 1);
        check_eq("warm0_din", din1, 8'h00);
        check_eq("warm0_ctrl", {rst1, avg1, en1}, 3'b000);
        check_eq("warm0_ready", bus1.cmd_ready, 0);
        @(negedge CLOCK);
        check_eq("warm1_step", step1, 1);
        check_eq("warm1_din", din1, Seed);
        check_eq("warm1_ctrl", {rst1, avg1, en1}, 3'b000);
        check_eq("warm1_ready", bus1.cmd_ready, 0);
        @(negedge CLOCK);
        check_eq("idle_ready", bus1.cmd_ready, 1);
        check_eq("idle_step", step1, 0);
        check_eq("idle_busy", busy1, 0);
    endtask

    // Issue one command from an IDLE negedge; walk EXEC, CAPT, RESP and handshake
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] stub,
                           input int hold, input logic [15:0] exp_c1, input logic [1:0] exp_c2,
                           input logic [2:0] exp_ctrl);
        stub_next      = stub;
        bus1.cmd_op    = op;
        bus1.cmd_data  = d;
        bus1.cmd_valid = 1'b1;
        check_eq("cmd_ready", bus1.cmd_ready, 1);
        @(negedge CLOCK);
        bus1.cmd_valid = 1'b0;
        check_eq("exec_step", step1, 1);
        check_eq("exec_ctrl", {rst1, avg1, en1}, exp_ctrl);
        check_eq("exec_din", din1, d);
        check_eq("exec_ready", bus1.cmd_ready, 0);
        check_eq("exec_busy", busy1, 1);
        @(negedge CLOCK);
        check_eq("capt_step", step1, 0);
        check_eq("capt_valid", bus1.rsp_valid, 0);
        @(negedge CLOCK);
        check_eq("rsp_valid", bus1.rsp_valid, 1);
        check_eq("rsp_data", bus1.rsp_data, stub);
        check_eq("rsp_op", bus1.rsp_op, op);
        check_eq("count", cnt1, exp_c1);
        check_eq("count_sat", cnt2, exp_c2);
        jitter = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus1.cmd_valid = 1'b1;
            bus1.cmd_op    = 2'b01;
            @(negedge CLOCK);
            check_eq("bp_valid", bus1.rsp_valid, 1);
            check_eq("bp_data", bus1.rsp_data, stub);
            check_eq("bp_op", bus1.rsp_op, op);
            check_eq("bp_ready", bus1.cmd_ready, 0);
            check_eq("bp_step", step1, 0);
        end
        jitter         = 1'b0;
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        @(negedge CLOCK);
        bus1.rsp_ready = 1'b0;
        check_eq("done_valid", bus1.rsp_valid, 0);
        check_eq("done_ready", bus1.cmd_ready, 1);
        check_eq("done_count", cnt1, exp_c1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        core_out       = 8'h00;
        stub_next      = 8'h00;
        jitter         = 1'b0;
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op    = 2'b00;
        bus1.cmd_data  = 8'h10;
        bus1.rsp_ready = 1'b0;
        #1 RESET = 1'b1;
        #2;
        check_eq("rst_ready", bus1.cmd_ready, 0);
        check_eq("rst_valid", bus1.rsp_valid, 0);
        check_eq("rst_step", step1, 0);
        check_eq("rst_busy", busy1, 1);
        check_eq("rst_count", cnt1, 0);
        check_eq("rst_rsp", {bus1.rsp_data, bus1.rsp_op}, 10'h000);

        // Warm-up with the first command already held on the channel
        @(negedge CLOCK);
        warm_checks();
        //       op     data   stub   hold cnt  sat  {rst,avg,en}
        run_cmd(2'b00, 8'h10, 8'h08, 0,  16'd1, 2'd1, 3'b001);
        run_cmd(2'b01, 8'h7F, 8'h3C, 0,  16'd2, 2'd2, 3'b011);
        run_cmd(2'b10, 8'h80, 8'hC3, 0,  16'd2, 2'd2, 3'b100);
        run_cmd(2'b11, 8'h22, 8'h44, 0,  16'd2, 2'd2, 3'b000);
        run_cmd(2'b00, 8'h01, 8'h81, 10, 16'd3, 2'd3, 3'b001);
        run_cmd(2'b00, 8'hFF, 8'hFE, 0,  16'd4, 2'd3, 3'b001);
        run_cmd(2'b00, 8'h55, 8'hAA, 0,  16'd5, 2'd3, 3'b001);
        run_cmd(2'b11, 8'h66, 8'h99, 0,  16'd5, 2'd3, 3'b000);

        // Reset while a response is pending
        stub_next      = 8'h77;
        bus1.cmd_op    = 2'b01;
        bus1.cmd_data  = 8'h33;
        bus1.cmd_valid = 1'b1;
        @(negedge CLOCK);
        bus1.cmd_valid = 1'b0;
        repeat (2) @(negedge CLOCK);
        check_eq("pre_rst_valid", bus1.rsp_valid, 1);
        #2 RESET = 1'b1;
        #1;
        check_eq("mid_rst_valid", bus1.rsp_valid, 0);
        check_eq("mid_rst_busy", busy1, 1);
        check_eq("mid_rst_count", cnt1, 0);
        check_eq("mid_rst_count_sat", cnt2, 0);
        check_eq("mid_rst_ready", bus1.cmd_ready, 0);
        @(negedge CLOCK);
        warm_checks();
        run_cmd(2'b00, 8'h0C, 8'h0D, 0, 16'd1, 2'd1, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
